// File: rtl/cic3_pkg.sv
// Shared types and constants for divided-clock consumers of cic3_clkdiv.
package cic3_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int FRAME_CNT_W           = 8;
  localparam int DEF_DECIMATION_FACTOR = 256;

endpackage

// File: rtl/cic3_frame_serializer_if.sv
// Bus between the CIC datapaths / readout logic and the frame serializer.
interface cic3_frame_serializer_if
  import cic3_pkg::*;
#(
    parameter int NUMBITS      = 25,
    parameter int NUM_CHANNELS = 4
);
    // No valid/ready pair here: divided_clk rising is the only "request"; the serializer
    // cannot stall it, so a request that lands while busy is dropped and flagged via overrun.
    logic                              divided_clk;
    logic [NUM_CHANNELS*NUMBITS-1:0]   cic_data;
    logic                              enable;
    logic                              clr_overrun;
    logic                              serial_out;
    logic                              frame_sync;
    logic                              busy;
    logic                              overrun;
    logic [FRAME_CNT_W-1:0]            frame_count;
    ser_state_t                        dbg_state;

    modport master (
        output divided_clk, cic_data, enable, clr_overrun,
        input  serial_out, frame_sync, busy, overrun, frame_count, dbg_state
    );

    modport slave (
        input  divided_clk, cic_data, enable, clr_overrun,
        output serial_out, frame_sync, busy, overrun, frame_count, dbg_state
    );

endinterface

// File: rtl/cic3_div_edge_detect.sv
// Rising-edge detector for the decimated clock, sampled in the fast clk domain.
module cic3_div_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_div_clk,
    output logic o_rise
);

    logic r_div_q;
    logic r_armed;

    // r_armed keeps a divided_clk that is already high at reset release from looking like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_div_q <= i_div_clk;
            if (!i_div_clk) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = i_div_clk & ~r_div_q & r_armed;

endmodule

// File: rtl/cic3_frame_serializer.sv
// Captures NUM_CHANNELS CIC3 words on each divided_clk rise and shifts them out MSB first, ch0 first.
module cic3_frame_serializer
  import cic3_pkg::*;
#(
    parameter int DECIMATION_FACTOR = DEF_DECIMATION_FACTOR,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
    parameter int NUM_CHANNELS      = 4
) (
    input logic                    clk,
    input logic                    reset_n,
    cic3_frame_serializer_if.slave bus
);

    localparam int TOTAL_BITS = NUM_CHANNELS*NUMBITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS);

    if (TOTAL_BITS >= DECIMATION_FACTOR) begin : g_frame_too_long
        $error("cic3_frame_serializer: frame of %0d bits does not fit in %0d clk periods",
               TOTAL_BITS, DECIMATION_FACTOR);
    end

    ser_state_t             r_state;
    ser_state_t             w_next_state;
    logic                   w_rise;
    logic                   w_start;
    logic                   w_last;
    logic [TOTAL_BITS-1:0]  w_frame;
    logic [TOTAL_BITS-1:0]  r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_serial;
    logic                   r_sync;
    logic                   r_busy;
    logic                   r_overrun;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    cic3_div_edge_detect u_edge (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_div_clk (bus.divided_clk),
        .o_rise    (w_rise)
    );

    // Channel 0 lands in the top word so a plain MSB-first shift emits it first.
    always_comb begin
        w_frame = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_frame[(NUM_CHANNELS-1-c)*NUMBITS +: NUMBITS] = bus.cic_data[c*NUMBITS +: NUMBITS];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise && bus.enable) begin
                    w_next_state = SHIFT;
                    w_start      = 1'b1;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == '0) begin
                    w_next_state = IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // bit_cnt counts the bits still to be shown after the one currently on serial_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_serial    <= 1'b0;
            r_sync      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_start) begin
            r_serial    <= w_frame[TOTAL_BITS-1];
            r_shreg     <= {w_frame[TOTAL_BITS-2:0], 1'b0};
            r_bit_cnt   <= CNT_W'(TOTAL_BITS-1);
            r_sync      <= 1'b1;
            r_busy      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end else if (r_state == SHIFT) begin
            r_sync <= 1'b0;
            if (w_last) begin
                r_serial <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                r_serial  <= r_shreg[TOTAL_BITS-1];
                r_shreg   <= {r_shreg[TOTAL_BITS-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
        end
    end

    // A rise during SHIFT, including the last-bit cycle, is a dropped sample; set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_rise && (r_state == SHIFT)) begin
            r_overrun <= 1'b1;
        end else if (bus.clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.serial_out  = r_serial;
    assign bus.frame_sync  = r_sync;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;
    assign bus.frame_count = r_frame_cnt;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_cic3_frame_serializer.sv
// Directed bench for cic3_frame_serializer at default parameters (100-bit frames, D=256).
module tb_cic3_frame_serializer;
    import cic3_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    int          errors = 0;
    int          checks = 0;
    logic [99:0] exp_frame;

    always #5 clk = ~clk;

    cic3_frame_serializer_if #(.NUMBITS(25), .NUM_CHANNELS(4)) bus ();

    cic3_frame_serializer #(.DECIMATION_FACTOR(256)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [24:0] c0, input logic [24:0] c1,
                            input logic [24:0] c2, input logic [24:0] c3);
        bus.cic_data = {c3, c2, c1, c0};
        exp_frame    = {c0, c1, c2, c3};
    endtask

    // Entered at the negedge where bit 0 should be visible; leaves at the cycle after the last bit.
    task automatic check_frame(input logic [7:0] exp_cnt, input int glitch_at, input int ovr_from);
        chk("frame_count_start", 32'(bus.frame_count), 32'(exp_cnt));
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("serial_bit%0d", k), 32'(bus.serial_out), 32'(exp_frame[99-k]));
            chk($sformatf("frame_sync_bit%0d", k), 32'(bus.frame_sync), 32'(k == 0));
            chk($sformatf("busy_bit%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("overrun_bit%0d", k), 32'(bus.overrun), 32'(k >= ovr_from));
            if (k == glitch_at - 1) bus.divided_clk = 1'b0;
            if (k == glitch_at) bus.divided_clk = 1'b1;
            tick();
        end
        chk("busy_after_frame", 32'(bus.busy), 32'd0);
        chk("serial_after_frame", 32'(bus.serial_out), 32'd0);
        chk("sync_after_frame", 32'(bus.frame_sync), 32'd0);
        chk("overrun_after_frame", 32'(bus.overrun), 32'(100 >= ovr_from));
        chk("frame_count_end", 32'(bus.frame_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.divided_clk = 1'b0;
        bus.enable      = 1'b1;
        bus.clr_overrun = 1'b0;
        set_data(25'h1ABCDEF, 25'h0000001, 25'h1FFFFFF, 25'h0);

        // 1. reset held while divided_clk toggles
        for (int i = 0; i < 6; i++) begin
            bus.divided_clk = ~bus.divided_clk;
            tick();
        end
        chk("rst_serial", 32'(bus.serial_out), 32'd0);
        chk("rst_sync", 32'(bus.frame_sync), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        bus.divided_clk = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // 2. single frame
        bus.divided_clk = 1'b1;
        tick();
        check_frame(8'd1, -10, 1000);
        tick(3);
        chk("single_no_restart", 32'(bus.busy), 32'd0);

        // 3. closed loop, 256-cycle divided period
        bus.divided_clk = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: set_data(25'h1555555, 25'h0AAAAAA, 25'h1234567, 25'h0F0F0F0);
                1: set_data(25'h0000000, 25'h1FFFFFF, 25'h0000000, 25'h1FFFFFF);
                2: set_data(25'h1000000, 25'h0000001, 25'h1800001, 25'h0C3C3C3);
                default: set_data(25'h0ACE135, 25'h1BDF246, 25'h0123456, 25'h1FEDCBA);
            endcase
            bus.divided_clk = 1'b1;
            tick();
            check_frame(8'(p + 1), -10, 1000);
            tick(27);
            bus.divided_clk = 1'b0;
            tick(128);
        end
        chk("loop_overrun", 32'(bus.overrun), 32'd0);

        // 4. second rise mid-frame, then a rise on the last bit
        set_data(25'h1ABCDEF, 25'h0000001, 25'h1FFFFFF, 25'h0);
        bus.divided_clk = 1'b1;
        tick();
        check_frame(8'd5, 49, 50);
        tick(2);
        chk("ovr_no_new_frame", 32'(bus.busy), 32'd0);
        chk("ovr_count_hold", 32'(bus.frame_count), 32'd5);
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);
        bus.divided_clk = 1'b0;
        tick();
        set_data(25'h0123456, 25'h1654321, 25'h0000FFF, 25'h1FFF000);
        bus.divided_clk = 1'b1;
        tick();
        check_frame(8'd6, 99, 100);
        tick(3);
        chk("lastbit_no_new_frame", 32'(bus.busy), 32'd0);
        chk("lastbit_count_hold", 32'(bus.frame_count), 32'd6);
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("lastbit_ovr_cleared", 32'(bus.overrun), 32'd0);

        // 5. reset mid-frame, released with divided_clk high
        bus.divided_clk = 1'b0;
        tick();
        bus.divided_clk = 1'b1;
        tick(31);
        chk("mid_busy_before_rst", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_serial", 32'(bus.serial_out), 32'd0);
        chk("mid_rst_sync", 32'(bus.frame_sync), 32'd0);
        chk("mid_rst_count", 32'(bus.frame_count), 32'd0);
        tick(3);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst_idle%0d", i), 32'(bus.busy), 32'd0);
        end
        bus.divided_clk = 1'b0;
        tick();
        bus.divided_clk = 1'b1;
        tick();
        check_frame(8'd1, -10, 1000);

        // 6. enable low over three rises, then re-enabled
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.divided_clk = 1'b0;
            tick(2);
            bus.divided_clk = 1'b1;
            tick();
            chk($sformatf("dis_sync%0d", i), 32'(bus.frame_sync), 32'd0);
            chk($sformatf("dis_busy%0d", i), 32'(bus.busy), 32'd0);
            tick(3);
        end
        chk("dis_count", 32'(bus.frame_count), 32'd1);
        chk("dis_overrun", 32'(bus.overrun), 32'd0);
        bus.enable = 1'b1;
        bus.divided_clk = 1'b0;
        tick();
        set_data(25'h1ABCDEF, 25'h0000001, 25'h1FFFFFF, 25'h0);
        bus.divided_clk = 1'b1;
        tick();
        check_frame(8'd2, -10, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
